// File: rtl/mem_arbiter.sv
// Two-port SRAM arbiter: instruction fetch and data ports share one SRAM.
// Conflicts alternate between ports; each access takes WAIT_CYCLES cycles.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sel,
    output logic              busy
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_sram_en;
    logic              r_sram_we;
    logic              r_if_ready;
    logic              r_dm_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic              w_any_req;
    logic              w_grant_dm;

    // r_grant doubles as last_grant while idle, so a conflict goes to the other port.
    assign w_any_req  = if_req | dm_req;
    assign w_grant_dm = (if_req && dm_req) ? ~r_grant : dm_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_grant    <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_sram_en  <= 1'b0;
            r_sram_we  <= 1'b0;
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant   <= w_grant_dm;
                        r_we      <= w_grant_dm & dm_we;
                        r_addr    <= w_grant_dm ? dm_addr : if_addr;
                        r_wdata   <= dm_wdata;
                        r_cnt     <= '0;
                        r_sram_en <= 1'b1;
                        r_sram_we <= w_grant_dm & dm_we;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_sram_en <= 1'b0;
                        r_sram_we <= 1'b0;
                        r_state   <= S_DONE;
                        if (r_grant) begin
                            r_dm_ready <= 1'b1;
                            if (!r_we) r_dm_rdata <= sram_rdata;
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= sram_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_rdata   = r_if_rdata;
    assign if_ready   = r_if_ready;
    assign dm_rdata   = r_dm_rdata;
    assign dm_ready   = r_dm_ready;
    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign sel        = r_grant;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 3, SRAM access cycles (legal values >= 1).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port if_req  input  1  fetch read request, level, held until if_ready.
REQ-007 SHALL have port if_addr  input  ADDR_W  fetch address.
REQ-008 SHALL have port if_rdata  output  DATA_W  fetch read data.
REQ-009 SHALL have port if_ready  output  1  one-cycle fetch completion pulse.
REQ-010 SHALL have port dm_req  input  1  data request, level, held until dm_ready.
REQ-011 SHALL have port dm_we  input  1  data write enable (1 = write).
REQ-012 SHALL have port dm_addr  input  ADDR_W  data address.
REQ-013 SHALL have port dm_wdata  input  DATA_W  data write value.
REQ-014 SHALL have port dm_rdata  output  DATA_W  data read data.
REQ-015 SHALL have port dm_ready  output  1  one-cycle data completion pulse.
REQ-016 SHALL have port sram_en  output  1  SRAM access enable.
REQ-017 SHALL have port sram_we  output  1  SRAM write enable.
REQ-018 SHALL have port sram_addr  output  ADDR_W  SRAM address.
REQ-019 SHALL have port sram_wdata  output  DATA_W  SRAM write data.
REQ-020 SHALL have port sram_rdata  input  DATA_W  SRAM read data, valid in last ACCESS cycle.
REQ-021 SHALL have port sel  output  1  address/data mux select: 0 = fetch, 1 = data.
REQ-022 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-023 SHALL implement states IDLE, ACCESS, DONE; all outputs registered or decoded from registered state only.
REQ-024 In IDLE with any request high, SHALL latch grant, address, wdata, and we (0 for fetch), then enter ACCESS next cycle.
REQ-025 With exactly one request high, SHALL grant that requester.
REQ-026 With both requests high, SHALL grant the requester not granted last; last_grant resets to fetch, so the first conflict goes to data.
REQ-027 SHALL hold ACCESS for exactly WAIT_CYCLES cycles via a counter, then enter DONE.
REQ-028 In ACCESS, SHALL assert sram_en = 1 and drive sram_addr/sram_wdata from the latched values; sram_we equals the latched we.
REQ-029 On the last ACCESS cycle of a read, SHALL capture sram_rdata into the granted port's rdata register.
REQ-030 In DONE, SHALL pulse the granted port's ready for exactly one cycle, then return to IDLE.
REQ-031 Latency: a request sampled in IDLE at cycle T SHALL produce ready at cycle T+1+WAIT_CYCLES.
REQ-032 SHALL ignore requests in ACCESS and DONE; a request held through them is arbitrated in the following IDLE cycle.
REQ-033 if_rdata/dm_rdata SHALL hold their value until the next read completion to that port; writes SHALL NOT modify dm_rdata.
REQ-034 sel SHALL equal the latched grant and remain stable through ACCESS and DONE.
REQ-035 Outside ACCESS, sram_en and sram_we SHALL be 0.

Reset
REQ-036 On rst, SHALL enter IDLE next edge with: ready outputs 0, sram_en 0, sram_we 0, sel 0, busy 0, rdata registers 0, counter 0, last_grant = fetch.
REQ-037 rst during ACCESS or DONE SHALL abort the transfer, with no ready pulse and no rdata update.

Verification (WAIT_CYCLES = 3, reset released before cycle 1)
REQ-038 Fetch alone: if_req=1, if_addr=0x40 at cycle 1; sram_rdata=0xE3A01005 -> sram_en=1 in cycles 2-4, if_ready=1 in cycle 5 only, if_rdata=0xE3A01005, sel=0.
REQ-039 Simultaneous first requests: both high at cycle 1 -> data granted (sel=1), dm_ready in cycle 5; fetch granted in cycle 6 IDLE, if_ready in cycle 10.
REQ-040 Data write: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> sram_we=1 and sram_addr=0x100 in cycles 2-4, dm_ready in cycle 5, dm_rdata unchanged.
REQ-041 Continuous conflict: both requests held high -> grant sequence data, fetch, data, fetch; each ready arrives 5 cycles apart.
REQ-042 Reset mid-access: rst=1 in cycle 3 of a fetch -> no if_ready, busy=0, sram_en=0, if_rdata=0 from cycle 4.
REQ-043 Late request: dm_req rises in cycle 2 during a fetch access -> dm request ignored until cycle 6 IDLE, granted there, dm_ready in cycle 10.
